xgs_line_checker: RTL and testbench

XGS_LINE_CHECKER -- requirements
Module: xgs_line_checker

---
 rtl/xgs_line_checker.sv | 131 +++++++++++++
 tb/tb_xgs_line_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgs_line_checker.sv
// Frame checker for a video stream carrying an 8-bit incrementing test pattern.
// It counts pixel and marker errors per beat and records where the first error occurred.
module xgs_line_checker #(
    parameter int DW   = 64,
    parameter int CNTW = 16
) (
    input  logic            sysclk,
    input  logic            sysrst,
    input  logic            cfg_start,
    input  logic [11:0]     cfg_line_beats,
    input  logic [11:0]     cfg_lines,
    input  logic [7:0]      cfg_seed,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [DW-1:0]   s_axis_tdata,
    input  logic [3:0]      s_axis_tuser,
    output logic            busy,
    output logic            frame_done,
    output logic [CNTW-1:0] data_err_cnt,
    output logic [CNTW-1:0] proto_err_cnt,
    output logic            first_err_valid,
    output logic [11:0]     first_err_x,
    output logic [11:0]     first_err_y
);

    localparam int NB = DW / 8;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t      state;
    logic [11:0] line_beats_q;
    logic [11:0] lines_q;
    logic [7:0]  seed_q;
    logic [11:0] pos_x;
    logic [11:0] pos_y;

    logic [7:0]    base;
    logic [NB-1:0] pix_bad;
    logic [3:0]    exp_user;
    logic          last_x;
    logic          last_y;
    logic          accept;
    logic          data_bad;
    logic          proto_bad;

    // Pixel 0 of the current beat; the remaining pixels follow at +1 with 8-bit wrap.
    assign base = seed_q + pos_y[7:0] + 8'(pos_x * NB);

    for (genvar k = 0; k < NB; k++) begin : g_pix
        assign pix_bad[k] = s_axis_tdata[8*k +: 8] != (base + 8'(k));
    end

    assign last_x    = pos_x == line_beats_q - 12'd1;
    assign last_y    = pos_y == lines_q - 12'd1;
    assign exp_user  = {last_x, pos_x == 12'd0, last_x && last_y, (pos_x == 12'd0) && (pos_y == 12'd0)};
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign data_bad  = |pix_bad;
    assign proto_bad = s_axis_tuser != exp_user;

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state           <= IDLE;
            line_beats_q    <= '0;
            lines_q         <= '0;
            seed_q          <= '0;
            pos_x           <= '0;
            pos_y           <= '0;
            s_axis_tready   <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            data_err_cnt    <= '0;
            proto_err_cnt   <= '0;
            first_err_valid <= 1'b0;
            first_err_x     <= '0;
            first_err_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (cfg_start && cfg_line_beats != 12'd0 && cfg_lines != 12'd0) begin
                        state           <= ACTIVE;
                        line_beats_q    <= cfg_line_beats;
                        lines_q         <= cfg_lines;
                        seed_q          <= cfg_seed;
                        pos_x           <= '0;
                        pos_y           <= '0;
                        s_axis_tready   <= 1'b1;
                        busy            <= 1'b1;
                        data_err_cnt    <= '0;
                        proto_err_cnt   <= '0;
                        first_err_valid <= 1'b0;
                        first_err_x     <= '0;
                        first_err_y     <= '0;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (data_bad && data_err_cnt != {CNTW{1'b1}})
                            data_err_cnt <= data_err_cnt + 1'b1;
                        if (proto_bad && proto_err_cnt != {CNTW{1'b1}})
                            proto_err_cnt <= proto_err_cnt + 1'b1;
                        if ((data_bad || proto_bad) && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_x     <= pos_x;
                            first_err_y     <= pos_y;
                        end
                        // Position is purely beat-counted; markers never resynchronise it.
                        if (last_x) begin
                            pos_x <= '0;
                            pos_y <= pos_y + 12'd1;
                        end else begin
                            pos_x <= pos_x + 12'd1;
                        end
                        if (last_x && last_y) begin
                            state         <= DONE;
                            s_axis_tready <= 1'b0;
                            frame_done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgs_line_checker.sv
// Scoreboard bench for xgs_line_checker: directed frames push expected results,
// a monitor pops and compares them on every frame_done pulse.
module tb_xgs_line_checker;

    logic        sysclk = 1'b0;
    logic        sysrst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [11:0] cfg_line_beats = '0;
    logic [11:0] cfg_lines = '0;
    logic [7:0]  cfg_seed = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tuser = '0;
    logic        busy;
    logic        frame_done;
    logic [15:0] data_err_cnt;
    logic [15:0] proto_err_cnt;
    logic        first_err_valid;
    logic [11:0] first_err_x;
    logic [11:0] first_err_y;

    typedef struct {
        logic [15:0] d;
        logic [15:0] p;
        logic        v;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   frames_seen = 0;
    int   frames_expected = 0;

    xgs_line_checker #(.DW(64), .CNTW(16)) dut (
        .sysclk(sysclk),
        .sysrst(sysrst),
        .cfg_start(cfg_start),
        .cfg_line_beats(cfg_line_beats),
        .cfg_lines(cfg_lines),
        .cfg_seed(cfg_seed),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser),
        .busy(busy),
        .frame_done(frame_done),
        .data_err_cnt(data_err_cnt),
        .proto_err_cnt(proto_err_cnt),
        .first_err_valid(first_err_valid),
        .first_err_x(first_err_x),
        .first_err_y(first_err_y)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timeout, got no response, expected one", name);
    endtask

    function automatic logic [63:0] genBeat(input logic [7:0] seed, input int x, input int y);
        logic [63:0] b;
        for (int k = 0; k < 8; k++)
            b[k*8 +: 8] = 8'(int'(seed) + y + 8*x + k);
        return b;
    endfunction

    function automatic logic [3:0] genUser(input int x, input int y, input int lb, input int nl);
        logic eol;
        eol = (x == lb - 1);
        return {eol, x == 0, eol && (y == nl - 1), (x == 0) && (y == 0)};
    endfunction

    function automatic exp_t mkExp(input logic [15:0] d, input logic [15:0] p, input logic v,
                                   input logic [11:0] x, input logic [11:0] y);
        exp_t e;
        e.d = d; e.p = p; e.v = v; e.x = x; e.y = y;
        return e;
    endfunction

    // Compares the counters against the oldest outstanding expectation on each completion pulse.
    always @(negedge sysclk) begin
        if (frame_done) begin
            exp_t e;
            frames_seen++;
            if (sb.size() == 0) begin
                timeoutFail("unexpected_frame_done");
            end else begin
                e = sb.pop_front();
                checkOutput("data_err_cnt", 32'(data_err_cnt), 32'(e.d));
                checkOutput("proto_err_cnt", 32'(proto_err_cnt), 32'(e.p));
                checkOutput("first_err_valid", 32'(first_err_valid), 32'(e.v));
                checkOutput("first_err_x", 32'(first_err_x), 32'(e.x));
                checkOutput("first_err_y", 32'(first_err_y), 32'(e.y));
                checkOutput("busy_during_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic startFrame(input logic [7:0] seed, input int lb, input int nl);
        @(negedge sysclk);
        cfg_seed       = seed;
        cfg_line_beats = 12'(lb);
        cfg_lines      = 12'(nl);
        cfg_start      = 1'b1;
        @(negedge sysclk);
        cfg_start      = 1'b0;
    endtask

    task automatic sendBeat(input logic [63:0] d, input logic [3:0] u, input bit gap);
        int budget = 0;
        if (gap) begin
            int n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) @(negedge sysclk);
        end
        @(negedge sysclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        while (!s_axis_tready && budget < 100) begin
            @(negedge sysclk);
            budget++;
        end
        if (!s_axis_tready) timeoutFail("tready_wait");
        @(posedge sysclk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge sysclk);
        while (busy && n < 50) begin
            @(negedge sysclk);
            n++;
        end
        if (busy) timeoutFail("busy_fall");
    endtask

    // Whole frame of pattern beats; optional single byte-3 corruption, all-beat corruption and a stray start pulse.
    task automatic applyStimulus(input logic [7:0] seed, input int lb, input int nl,
                                 input int bad_x, input int bad_y, input bit all_bad,
                                 input bit gaps, input bit mid_start);
        logic [63:0] d;
        int          beat = 0;
        startFrame(seed, lb, nl);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < lb; x++) begin
                d = genBeat(seed, x, y);
                if (all_bad || (x == bad_x && y == bad_y)) d[31:24] = ~d[31:24];
                sendBeat(d, genUser(x, y, lb, nl), gaps);
                beat++;
                if (mid_start && beat == 5) begin
                    @(negedge sysclk);
                    cfg_seed = 8'h55; cfg_line_beats = 12'd2; cfg_lines = 12'd2; cfg_start = 1'b1;
                    @(negedge sysclk);
                    cfg_start = 1'b0;
                end
            end
        end
        waitIdle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_data_err_cnt"}, 32'(data_err_cnt), 32'd0);
        checkOutput({tag, "_proto_err_cnt"}, 32'(proto_err_cnt), 32'd0);
        checkOutput({tag, "_first_err_valid"}, 32'(first_err_valid), 32'd0);
        checkOutput({tag, "_first_err_x"}, 32'(first_err_x), 32'd0);
        checkOutput({tag, "_first_err_y"}, 32'(first_err_y), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        checkAllZero("reset");
        sysrst = 1'b0;
        @(negedge sysclk);

        // Zero-sized configuration must not arm the checker.
        startFrame(8'h10, 0, 3);
        checkOutput("zero_cfg_busy", 32'(busy), 32'd0);
        checkOutput("zero_cfg_tready", 32'(s_axis_tready), 32'd0);

        // Clean frame with random tvalid gaps.
        sb.push_back(mkExp(16'd0, 16'd0, 1'b0, 12'd0, 12'd0)); frames_expected++;
        applyStimulus(8'h10, 4, 3, -1, -1, 1'b0, 1'b1, 1'b0);

        // Byte 3 of beat x=2, y=1 corrupted.
        sb.push_back(mkExp(16'd1, 16'd0, 1'b1, 12'd2, 12'd1)); frames_expected++;
        applyStimulus(8'h10, 4, 3, 2, 1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge sysclk);
        checkOutput("idle_hold_data_err", 32'(data_err_cnt), 32'd1);
        checkOutput("idle_hold_first_x", 32'(first_err_x), 32'd2);

        // Single-beat frame carrying all four markers, then the same beat with SOF|SOL only.
        sb.push_back(mkExp(16'd0, 16'd0, 1'b0, 12'd0, 12'd0)); frames_expected++;
        startFrame(8'h00, 1, 1);
        sendBeat(64'h0706050403020100, 4'hF, 1'b0);
        waitIdle();
        sb.push_back(mkExp(16'd0, 16'd1, 1'b1, 12'd0, 12'd0)); frames_expected++;
        startFrame(8'h00, 1, 1);
        sendBeat(64'h0706050403020100, 4'h5, 1'b0);
        waitIdle();

        // Seed wrap: bytes run 0xFE, 0xFF, 0x00, ...
        sb.push_back(mkExp(16'd0, 16'd0, 1'b0, 12'd0, 12'd0)); frames_expected++;
        startFrame(8'hFE, 2, 2);
        sendBeat(64'h0504030201_00FFFE, 4'h5, 1'b0);
        sendBeat(64'h0D0C0B0A09080706, 4'h8, 1'b0);
        sendBeat(64'h0605040302010_0FF, 4'h4, 1'b0);
        sendBeat(64'h0E0D0C0B0A090807, 4'hA, 1'b0);
        waitIdle();

        // Stray start mid-frame is ignored, so the original config still checks clean.
        sb.push_back(mkExp(16'd0, 16'd0, 1'b0, 12'd0, 12'd0)); frames_expected++;
        applyStimulus(8'h10, 4, 3, -1, -1, 1'b0, 1'b0, 1'b1);

        // Saturation: 70000 corrupted beats.
        sb.push_back(mkExp(16'hFFFF, 16'd0, 1'b1, 12'd0, 12'd0)); frames_expected++;
        applyStimulus(8'h20, 1000, 70, -1, -1, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame after some errors: everything clears and no completion is reported.
        startFrame(8'h10, 4, 3);
        for (int i = 0; i < 5; i++)
            sendBeat(~genBeat(8'h10, i % 4, i / 4), 4'h0, 1'b0);
        @(negedge sysclk);
        checkOutput("pre_reset_data_err", 32'(data_err_cnt), 32'd5);
        sysrst = 1'b1;
        #1 checkAllZero("async_reset");
        repeat (2) @(negedge sysclk);
        sysrst = 1'b0;
        repeat (20) @(negedge sysclk);
        checkAllZero("post_reset");

        checkOutput("frames_seen", 32'(frames_seen), 32'(frames_expected));
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
